bcd_seg7_scan: RTL and testbench

Multiplexed 7-segment display driver that consumes packed BCD words from the binary-to-BCD converter stage and time-multiplexes them onto a common-anode display. It captures a new value on each one-cycle `Valid` pulse, which is wired to the converter's done strobe. It scans one digit per refresh slot, inserting an anti-ghosting blank interval between slots, with optional leading-zero blanking. It sits between the BCD converter and the board-level segment/anode pins.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/bcd_to_seg7.sv | 18 +
 rtl/bcd_seg7_scan.sv | 149 ++++++++++++++
 tb/tb_bcd_seg7_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// scan FSM states, blank/dash codes and the nibble-to-segment table.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (common-anode display).
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry n is the pattern for nibble value n; listed from 15 down to 0.
    // Non-decimal nibbles (10-15) all show a dash.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        SEG_DASH,       // 15
        SEG_DASH,       // 14
        SEG_DASH,       // 13
        SEG_DASH,       // 12
        SEG_DASH,       // 11
        SEG_DASH,       // 10
        7'b0010000,     // 9
        7'b0000000,     // 8
        7'b1111000,     // 7
        7'b0000010,     // 6
        7'b0010010,     // 5
        7'b0011001,     // 4
        7'b0110000,     // 3
        7'b0100100,     // 2
        7'b1111001,     // 1
        7'b1000000      // 0
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble decoder: turns one BCD digit plus a blank request
// into an active-low 7-segment pattern. Kept separate so other display
// blocks can reuse the same glyph table.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the digit so callers can mask digits without
    // having to know the blank code.
    always_comb begin
        seg = blank ? SEG_BLANK : SEG_PATTERNS[nibble];
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed common-anode display driver. A Valid strobe captures a
// packed BCD word into a shadow register; the shadow is copied to the
// displayed (active) register at the start of every slot so a digit never
// tears mid-slot. Each slot is a short all-off blank interval followed by
// the drive interval for one digit, with optional leading-zero blanking.
// Seg/An are registered from the next-state values so they change on the
// same edge as the FSM.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int DEC_DIGITS   = 2,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [DEC_DIGITS*4-1:0] DataBCD,
    input  logic                    Valid,
    output logic [6:0]              Seg,
    output logic [DEC_DIGITS-1:0]   An
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
    localparam int DW = DEC_DIGITS * 4;

    localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DEC_DIGITS - 1);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [DW-1:0]           shadow, shadow_n;
    logic [DW-1:0]           active, active_n;
    logic [DEC_DIGITS-1:0]   lz_mask;
    logic [DEC_DIGITS-1:0]   an_n;
    logic [3:0]              digit_n;
    logic                    blank_n;
    logic                    zero_above;
    logic [6:0]              seg_n;

    // Next-state logic for the scan FSM, slot counter, digit index and the
    // shadow/active pair. The active register is refreshed on every entry
    // to BLANK and takes a capture arriving on that same edge, so the first
    // slot after leaving OFF already shows the value that started the scan.
    always_comb begin
        shadow_n = Valid ? DataBCD : shadow;
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        active_n = active;
        case (state)
            OFF: begin
                if (Valid) begin
                    state_n  = BLANK;
                    cnt_n    = '0;
                    idx_n    = '0;
                    active_n = shadow_n;
                end
            end
            BLANK: begin
                cnt_n = cnt + 1'b1;
                if (cnt == LAST_BLANK) begin
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == LAST_CNT) begin
                    cnt_n    = '0;
                    idx_n    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    state_n  = BLANK;
                    active_n = shadow_n;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = OFF;
            end
        endcase
    end

    // Leading-zero mask from the value about to be displayed: digit i is
    // masked when it and every digit above it are zero. Digit 0 is never
    // masked, so a plain zero still shows.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = DEC_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (active_n[4*i +: 4] == 4'd0);
            lz_mask[i] = (LZ_BLANK != 0) && zero_above;
        end
    end

    // Pick the digit and anode for the upcoming cycle. A masked digit keeps
    // the slot timing but leaves all anodes off and segments blank.
    always_comb begin
        digit_n = 4'd0;
        an_n    = '1;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (idx_n == IW'(i)) begin
                digit_n = active_n[4*i +: 4];
                if (state_n == DRIVE && !lz_mask[i]) begin
                    an_n[i] = 1'b0;
                end
            end
        end
        blank_n = &an_n;
    end

    bcd_to_seg7 u_decode (
        .nibble (digit_n),
        .blank  (blank_n),
        .seg    (seg_n)
    );

    // State, counters and data registers; reset discards any captured value
    // and parks the scanner in OFF until the next capture.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= OFF;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shadow <= shadow_n;
            active <= active_n;
        end
    end

    // Output registers, loaded from next-state values so segment and anode
    // changes line up with the FSM edge and no input reaches a pin directly.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg <= SEG_BLANK;
            An  <= '1;
        end else begin
            Seg <= seg_n;
            An  <= an_n;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan with a 2-digit, 8-cycle-slot,
// 2-cycle-blank configuration. A behavioural model tracks elapsed cycles
// since the scan started and derives the expected outputs arithmetically;
// a compare process checks An/Seg on every falling edge, and a few literal
// expectations pin the model to hand-derived values.
module tb_bcd_seg7_scan;

    localparam int D  = 2;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int LZ = 1;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic [D*4-1:0] DataBCD = '0;
    logic           Valid = 1'b0;
    logic [6:0]     Seg;
    logic [D-1:0]   An;

    int checks = 0;
    int passes = 0;

    // Reference glyph table indexed by nibble value.
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // Model state: whether scanning has started, cycles since it started,
    // the last captured word and the word being displayed this slot.
    bit running = 1'b0;
    int t = 0;
    int m_shadow = 0;
    int m_active = 0;

    bcd_seg7_scan #(
        .DEC_DIGITS   (D),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B),
        .LZ_BLANK     (LZ)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .DataBCD (DataBCD),
        .Valid   (Valid),
        .Seg     (Seg),
        .An      (An)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [15:0] act,
                                input logic [15:0] exp_val);
        checks++;
        if (act === exp_val) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_val);
        end
    endtask

    // Expected outputs from the model: position in the slot decides blank vs
    // drive, slot number picks the digit, leading zeros come from shifting
    // the displayed word down to the digit and testing for zero.
    function automatic void model_outputs(output logic [D-1:0] an_e, output logic [6:0] seg_e);
        int pos, i, dig;
        an_e  = '1;
        seg_e = 7'h7F;
        if (running) begin
            pos = t % R;
            i   = (t / R) % D;
            dig = (m_active >> (4 * i)) & 15;
            if (pos >= B && !(i > 0 && LZ == 1 && (m_active >> (4 * i)) == 0)) begin
                an_e  = ~(D'(1) << i);
                seg_e = seg_tab[dig];
            end
        end
    endfunction

    // Advance the model on each active clock edge, or clear it on reset.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            running  = 1'b0;
            t        = 0;
            m_shadow = 0;
            m_active = 0;
        end else begin
            int new_shadow;
            new_shadow = Valid ? int'(DataBCD) : m_shadow;
            if (!running) begin
                if (Valid) begin
                    running  = 1'b1;
                    t        = 0;
                    m_active = new_shadow;
                end
            end else begin
                t++;
                if (t % R == 0) m_active = new_shadow;
            end
            m_shadow = new_shadow;
        end
    end

    // Compare DUT outputs with the model every falling edge.
    always @(negedge Clk) begin
        logic [D-1:0] an_e;
        logic [6:0]   seg_e;
        model_outputs(an_e, seg_e);
        check_output("An_model", 16'(An), 16'(an_e));
        check_output("Seg_model", 16'(Seg), 16'(seg_e));
    end

    // Pulse Valid for one cycle with the given word; returns just after the
    // capturing rising edge.
    task automatic apply_stimulus(input logic [D*4-1:0] word);
        @(negedge Clk);
        DataBCD = word;
        Valid   = 1'b1;
        @(negedge Clk);
        Valid   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        wait_cycles(2);
        Rst = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        Rst = 1'b0;

        // Idle after reset: display must stay dark with no capture.
        wait_cycles(100);
        check_output("idle_An", 16'(An), 16'h3);
        check_output("idle_Seg", 16'(Seg), 16'h7F);

        // 0x42: digit 0 shows "2", digit 1 shows "4", frame repeats.
        apply_stimulus(8'h42);
        check_output("42_blank_An", 16'(An), 16'h3);
        wait_cycles(2);
        check_output("42_d0_An", 16'(An), 16'h2);
        check_output("42_d0_Seg", 16'(Seg), 16'(7'b0100100));
        wait_cycles(8);
        check_output("42_d1_An", 16'(An), 16'h1);
        check_output("42_d1_Seg", 16'(Seg), 16'(7'b0011001));
        wait_cycles(16);
        check_output("42_d1_repeat", 16'(Seg), 16'(7'b0011001));

        // 0x07 with leading-zero blanking, then 0x00.
        do_reset();
        apply_stimulus(8'h07);
        wait_cycles(2);
        check_output("07_d0_Seg", 16'(Seg), 16'(7'b1111000));
        wait_cycles(8);
        check_output("07_d1_An", 16'(An), 16'h3);
        check_output("07_d1_Seg", 16'(Seg), 16'h7F);
        do_reset();
        apply_stimulus(8'h00);
        wait_cycles(2);
        check_output("00_d0_An", 16'(An), 16'h2);
        check_output("00_d0_Seg", 16'(Seg), 16'(7'b1000000));

        // 0xA3: dash on the upper digit.
        do_reset();
        apply_stimulus(8'hA3);
        wait_cycles(2);
        check_output("A3_d0_Seg", 16'(Seg), 16'(7'b0110000));
        wait_cycles(8);
        check_output("A3_d1_Seg", 16'(Seg), 16'(7'b0111111));

        // 0x11 showing, 0x99 arrives mid-slot: no tearing until next slot.
        do_reset();
        apply_stimulus(8'h11);
        wait_cycles(2);
        apply_stimulus(8'h99);
        wait_cycles(1);
        check_output("99_tear_Seg", 16'(Seg), 16'(7'b1111001));
        wait_cycles(6);
        check_output("99_d1_Seg", 16'(Seg), 16'(7'b0010000));
        wait_cycles(8);
        check_output("99_d0_Seg", 16'(Seg), 16'(7'b0010000));

        // Reset between clock edges while driving.
        do_reset();
        apply_stimulus(8'h58);
        wait_cycles(3);
        #2;
        Rst = 1'b1;
        #1;
        check_output("rst_async_An", 16'(An), 16'h3);
        check_output("rst_async_Seg", 16'(Seg), 16'h7F);
        wait_cycles(2);
        Rst = 1'b0;
        wait_cycles(30);
        check_output("rst_idle_An", 16'(An), 16'h3);

        // Randomized captures, including zeros and non-decimal nibbles.
        for (int n = 0; n < 2000; n++) begin
            @(negedge Clk);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0:       DataBCD = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
                    1:       DataBCD = 8'($urandom_range(0, 9));
                    2:       DataBCD = 8'h00;
                    default: DataBCD = 8'($urandom_range(0, 255));
                endcase
                Valid = 1'b1;
            end else begin
                Valid = 1'b0;
            end
            if (n == 1000) begin
                #2;
                Rst = 1'b1;
                #4;
                Rst = 1'b0;
            end
        end
        Valid = 1'b0;
        wait_cycles(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
